led_arbiter: RTL

- Shares the six active-low Cynthion FPGA LEDs between N_REQ independent requesters, such as a heartbeat blinker, a USB activity indicator and a debug pattern source.
- Arbitration is round-robin. Each owner is protected by a minimum hold time so a pattern stays visible long enough to read.
- A global PWM brightness gate is applied after arbitration.
- Sits between the requester blocks and the top-level led[5:0] pins. No other block drives the LEDs.

---
 rtl/led_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : led_arbiter
//  Purpose  : Shares the six active-low board LEDs between N_REQ requesters.
//             Ownership is granted round-robin. Each owner keeps the LEDs
//             for at least HOLD_CYCLES clocks, unless it releases them
//             earlier. A global PWM brightness gate is applied after
//             arbitration.
//  Ports    :
//    clk_60mhz   in   1           system clock, rising edge
//    rst_n       in   1           asynchronous active-low reset
//    req         in   N_REQ       level-sensitive request per requester
//    pattern     in   6*N_REQ     active-high pattern, requester i -> [6i+5:6i]
//    brightness  in   PWM_BITS    0 = dark, all-ones = full on
//    grant       out  N_REQ       one-hot current owner, zero when idle
//    busy        out  1           any grant active
//    led         out  6           LED pins, active-low
//  Revision : 1.0  initial release
// ============================================================================
module led_arbiter #(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 6000000,
  parameter int PWM_BITS    = 4
) (
  input  logic                  clk_60mhz,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [6*N_REQ-1:0]    pattern,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic [5:0]            led
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [HW-1:0]       HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0]       OWNER_RESET = IW'(N_REQ - 1);
  localparam logic [5:0]          LED_DARK    = 6'b111111;
  localparam logic [PWM_BITS-1:0] PWM_ONE     = PWM_BITS'(1);
  localparam logic [HW-1:0]       HOLD_ONE    = HW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  logic [0:0]          state_q, state_d;
  // owner_q doubles as the round-robin pointer: it holds the current owner
  // while in HOLD and the most recent owner while in IDLE.
  logic [IW-1:0]       owner_q, owner_d;
  logic [HW-1:0]       hold_q,  hold_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                busy_q,  busy_d;
  logic [5:0]          led_q,   led_d;

  logic [N_REQ-1:0]    rr_mask;
  logic                rr_found;
  logic [IW-1:0]       rr_idx;
  logic                pwm_en;

  // --------------------------------------------------------------------------
  // Per-requester pattern slices
  // --------------------------------------------------------------------------
  logic [5:0] pat_w [N_REQ];

  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_pat
      assign pat_w[g] = pattern[6*g +: 6];
    end
  endgenerate

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Scan candidates ptr+N, ..., ptr+1 (mod N_REQ) so that the nearest
  // successor of the pointer is written last and therefore wins.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] mask,
                                          input logic [IW-1:0]    ptr);
    logic          found;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    found = 1'b0;
    pick  = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (mask[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return {found, pick};
  endfunction

  // While holding, only the other requesters are candidates; the owner's
  // own request is judged separately (release vs. keep).
  assign rr_mask = (state_q == S_HOLD) ? (req & ~to_onehot(owner_q)) : req;
  assign {rr_found, rr_idx} = rr_pick(rr_mask, owner_q);

  // Full scale bypasses the comparator so all-ones means always on.
  assign pwm_en = (&brightness) || (pwm_q < brightness);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_60mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWNER_RESET;
      hold_q  <= '0;
      pwm_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      led_q   <= LED_DARK;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      pwm_q   <= pwm_q + PWM_ONE;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = (hold_q != '0) ? (hold_q - HOLD_ONE) : '0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d = S_HOLD;
          owner_d = rr_idx;
          hold_d  = HOLD_RELOAD;
        end
      end

      S_HOLD: begin
        if (!req[owner_q]) begin
          // Release wins over expiry; hand over directly if anyone waits.
          if (rr_found) begin
            owner_d = rr_idx;
            hold_d  = HOLD_RELOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else if ((hold_q == '0) && rr_found) begin
          owner_d = rr_idx;
          hold_d  = HOLD_RELOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (computed from the next state so grant, busy and led all
  // update on the same edge)
  // --------------------------------------------------------------------------
  always_comb begin
    grant_d = '0;
    busy_d  = 1'b0;
    led_d   = LED_DARK;
    if (state_d == S_HOLD) begin
      grant_d = to_onehot(owner_d);
      busy_d  = 1'b1;
      if (pwm_en) begin
        led_d = ~pat_w[owner_d];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign led   = led_q;

endmodule
`default_nettype wire
